// File: rtl/zdraw_sdram_wr_arbiter.sv
// zdraw_sdram_wr_arbiter
// Round-robin arbiter sharing the single 4-word-burst SDRAM write port among
// the draw engines. The winner's address and data are latched on the grant
// edge, the controller request is held until write-done (or a watchdog
// timeout), and a one-cycle done pulse is then returned to the winner.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   iReq                per-requester burst request (level, held until oDone)
//   iAddr / iData       per-requester burst address / 4 data words (word1 = LSB)
//   oGrant              one-hot owner of the write port, zero when idle
//   oDone               one-cycle completion pulse to the owner
//   oSDRAM_Wr_Addr      registered address to the controller
//   oSDRAM_Wr_Data1..4  registered data words to the controller
//   oSDRAM_Wr_Req       write request to the controller (level)
//   iSDRAM_Wr_Done      controller write-done
//   oBusy               high while a burst is in flight or being released
//   oErr / oErr_Src     sticky timeout flag and the requester that caused it
module zdraw_sdram_wr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          iReq,
    input  logic [NUM_REQ*ADDR_W-1:0]   iAddr,
    input  logic [NUM_REQ*4*DATA_W-1:0] iData,
    output logic [NUM_REQ-1:0]          oGrant,
    output logic [NUM_REQ-1:0]          oDone,
    output logic [ADDR_W-1:0]           oSDRAM_Wr_Addr,
    output logic [DATA_W-1:0]           oSDRAM_Wr_Data1,
    output logic [DATA_W-1:0]           oSDRAM_Wr_Data2,
    output logic [DATA_W-1:0]           oSDRAM_Wr_Data3,
    output logic [DATA_W-1:0]           oSDRAM_Wr_Data4,
    output logic                        oSDRAM_Wr_Req,
    input  logic                        iSDRAM_Wr_Done,
    output logic                        oBusy,
    output logic                        oErr,
    output logic [1:0]                  oErr_Src
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t            state, stateNext;
    logic [IDX_W-1:0]  ptr, owner, winner, cand;
    logic [IDX_W:0]    candSum;
    logic              anyReq;
    logic [CNT_W-1:0]  cnt;
    logic              timeUp, finish;

    logic [ADDR_W-1:0]   addrArr [NUM_REQ];
    logic [4*DATA_W-1:0] dataArr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
        assign addrArr[g] = iAddr[g*ADDR_W +: ADDR_W];
        assign dataArr[g] = iData[g*4*DATA_W +: 4*DATA_W];
    end

    // Round-robin search. Offsets are walked from farthest to nearest so the
    // requester closest to ptr (in wrap order) is the last one to win.
    always_comb begin
        winner  = ptr;
        anyReq  = 1'b0;
        cand    = ptr;
        candSum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            candSum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (candSum > {1'b0, LAST_IDX})
                candSum = candSum - (IDX_W+1)'(NUM_REQ);
            cand = candSum[IDX_W-1:0];
            if (iReq[cand]) begin
                winner = cand;
                anyReq = 1'b1;
            end
        end
    end

    // Done beats the watchdog when both land on the same cycle.
    assign timeUp = (cnt == CNT_LAST);
    assign finish = iSDRAM_Wr_Done || timeUp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = BUSY;
            BUSY:    if (finish) stateNext = RELEASE;
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        oBusy = (state != IDLE);
    end

    // Burst latch, handshake and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oGrant          <= '0;
            oDone           <= '0;
            oSDRAM_Wr_Addr  <= '0;
            oSDRAM_Wr_Data1 <= '0;
            oSDRAM_Wr_Data2 <= '0;
            oSDRAM_Wr_Data3 <= '0;
            oSDRAM_Wr_Data4 <= '0;
            oSDRAM_Wr_Req   <= 1'b0;
            oErr            <= 1'b0;
            oErr_Src        <= '0;
            ptr             <= '0;
            owner           <= '0;
            cnt             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        oSDRAM_Wr_Addr  <= addrArr[winner];
                        oSDRAM_Wr_Data1 <= dataArr[winner][0*DATA_W +: DATA_W];
                        oSDRAM_Wr_Data2 <= dataArr[winner][1*DATA_W +: DATA_W];
                        oSDRAM_Wr_Data3 <= dataArr[winner][2*DATA_W +: DATA_W];
                        oSDRAM_Wr_Data4 <= dataArr[winner][3*DATA_W +: DATA_W];
                        oSDRAM_Wr_Req   <= 1'b1;
                        oGrant          <= NUM_REQ'(1) << winner;
                        owner           <= winner;
                        cnt             <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        oSDRAM_Wr_Req <= 1'b0;
                        oDone         <= oGrant;
                        ptr           <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                        if (!iSDRAM_Wr_Done) begin
                            oErr     <= 1'b1;
                            oErr_Src <= 2'(owner);
                        end
                    end
                end
                RELEASE: begin
                    oDone  <= '0;
                    oGrant <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zdraw_sdram_wr_arbiter.sv
module tb_zdraw_sdram_wr_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   iReq;
    logic [NREQ*AW-1:0]   iAddr;
    logic [NREQ*4*DW-1:0] iData;
    logic [NREQ-1:0]   oGrant, oDone;
    logic [AW-1:0]     oSDRAM_Wr_Addr;
    logic [DW-1:0]     oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3, oSDRAM_Wr_Data4;
    logic              oSDRAM_Wr_Req, iSDRAM_Wr_Done, oBusy, oErr;
    logic [1:0]        oErr_Src;

    always #5 clk = ~clk;

    zdraw_sdram_wr_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .iReq(iReq), .iAddr(iAddr), .iData(iData),
        .oGrant(oGrant), .oDone(oDone), .oSDRAM_Wr_Addr(oSDRAM_Wr_Addr),
        .oSDRAM_Wr_Data1(oSDRAM_Wr_Data1), .oSDRAM_Wr_Data2(oSDRAM_Wr_Data2),
        .oSDRAM_Wr_Data3(oSDRAM_Wr_Data3), .oSDRAM_Wr_Data4(oSDRAM_Wr_Data4),
        .oSDRAM_Wr_Req(oSDRAM_Wr_Req), .iSDRAM_Wr_Done(iSDRAM_Wr_Done),
        .oBusy(oBusy), .oErr(oErr), .oErr_Src(oErr_Src));

    // per-lane stimulus
    logic [AW-1:0]   laneAddr [NREQ];
    logic [4*DW-1:0] laneData [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : gPack
        assign iAddr[g*AW +: AW]     = laneAddr[g];
        assign iData[g*4*DW +: 4*DW] = laneData[g];
    end

    int   npend [NREQ];
    bit   randMode, fixedLane;
    int   lat, reqCnt;
    logic [NREQ-1:0] prevGrant;
    int   grantLog [$];
    int   passCnt = 0, totalCnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: idle (0), burst in flight (1), release cycle (2).
    int          mPhase, mPtr, mOwner, mCyc, mErrSrc, mWin;
    logic [AW-1:0]   mAddr;
    logic [4*DW-1:0] mData;
    logic        mErr;
    logic [NREQ-1:0] expGrant;

    function automatic int rrPick(input logic [NREQ-1:0] req, input int ptr);
        int c;
        for (int o = 0; o < NREQ; o++) begin
            c = (ptr + o) % NREQ;
            if (req[2'(c)]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= 0; mPtr <= 0; mOwner <= 0; mCyc <= 0;
            mAddr <= '0; mData <= '0; mErr <= 1'b0; mErrSrc <= 0;
        end else if (mPhase == 0) begin
            mWin = rrPick(iReq, mPtr);
            if (mWin >= 0) begin
                mOwner <= mWin;
                mAddr  <= laneAddr[2'(mWin)];
                mData  <= laneData[2'(mWin)];
                mCyc   <= 0;
                mPhase <= 1;
            end
        end else if (mPhase == 1) begin
            if (iSDRAM_Wr_Done || mCyc == TO - 1) begin
                mPhase <= 2;
                mPtr   <= (mOwner + 1) % NREQ;
                if (!iSDRAM_Wr_Done) begin
                    mErr    <= 1'b1;
                    mErrSrc <= mOwner;
                end
            end
            mCyc <= mCyc + 1;
        end else begin
            mPhase <= 0;
        end
    end

    always @(negedge clk) begin
        expGrant = (mPhase != 0) ? (3'b001 << mOwner) : 3'b000;
        check("m_req",   128'(oSDRAM_Wr_Req), 128'(mPhase == 1));
        check("m_grant", 128'(oGrant), 128'(expGrant));
        check("m_done",  128'(oDone), 128'((mPhase == 2) ? expGrant : 3'b000));
        check("m_busy",  128'(oBusy), 128'(mPhase != 0));
        check("m_addr",  128'(oSDRAM_Wr_Addr), 128'(mAddr));
        check("m_data",  128'({oSDRAM_Wr_Data4, oSDRAM_Wr_Data3, oSDRAM_Wr_Data2, oSDRAM_Wr_Data1}), 128'(mData));
        check("m_err",   128'(oErr), 128'(mErr));
        if (mErr) check("m_errsrc", 128'(oErr_Src), 128'(mErrSrc));
        check("grant_onehot", 128'($countones(oGrant) <= 1), 128'(1));
    end

    // ---------------- stimulus ----------------
    function automatic int pickLat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return r + 1;
        if (r == 7) return TO;      // done on the last allowed cycle
        if (r == 8) return TO - 1;
        return 0;                   // never: watchdog fires
    endfunction

    // Encodes the grant log as base-4 digits (index+1) for compact compares.
    function automatic int logCode();
        int c = 0;
        foreach (grantLog[i]) c = c * 4 + grantLog[i] + 1;
        return c;
    endfunction

    task automatic step();
        logic [1:0] kk;
        @(negedge clk);
        if (oGrant != 0 && prevGrant == 0)
            for (int k = 0; k < NREQ; k++) if (oGrant[2'(k)]) grantLog.push_back(k);
        prevGrant = oGrant;
        for (int k = 0; k < NREQ; k++) begin
            kk = 2'(k);
            if (oDone[kk]) begin
                if (npend[kk] > 0) npend[kk]--;
                iReq[kk] = 1'b0;
            end else begin
                iReq[kk] = (npend[kk] > 0) && !(randMode && $urandom_range(0, 5) == 0);
            end
            if (fixedLane && k == 1) begin
                laneAddr[kk] = 24'h012345;
                laneData[kk] = 64'h4444_3333_2222_1111;
            end else begin
                laneAddr[kk] = 24'($urandom);
                laneData[kk] = {$urandom, $urandom};
            end
        end
        if (oSDRAM_Wr_Req) begin
            reqCnt++;
            if (reqCnt == 1 && randMode) lat = pickLat();
            iSDRAM_Wr_Done = (reqCnt == lat);
        end else begin
            reqCnt = 0;
            iSDRAM_Wr_Done = randMode && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic doReset();
        #1 rst = 1'b1;
        randMode = 0; fixedLane = 0; lat = 0;
        for (int k = 0; k < NREQ; k++) npend[k] = 0;
        step(); step();
        rst = 1'b0;
        prevGrant = '0;
        grantLog.delete();
    endtask

    task automatic drain(input int maxCyc, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxCyc; i++) begin
            step();
            if (npend[0] == 0 && npend[1] == 0 && npend[2] == 0 && !oBusy) begin
                ok = 1;
                break;
            end
        end
        check(name, 128'(ok), 128'(1));
    endtask

    int firstReq, reqHigh, doneCnt, doneAt;
    logic [NREQ-1:0] doneVal;

    task automatic watchBurst(input int n);
        firstReq = -1; reqHigh = 0; doneCnt = 0; doneAt = -1; doneVal = '0;
        for (int t = 1; t <= n; t++) begin
            step();
            if (oSDRAM_Wr_Req) begin reqHigh++; if (firstReq < 0) firstReq = t; end
            if (oDone != 0) begin doneCnt++; doneAt = t; doneVal = oDone; end
            if (t == 1 && fixedLane) begin
                check("sb_addr",  128'(oSDRAM_Wr_Addr), 128'(24'h012345));
                check("sb_data1", 128'(oSDRAM_Wr_Data1), 128'(16'h1111));
                check("sb_data2", 128'(oSDRAM_Wr_Data2), 128'(16'h2222));
                check("sb_data3", 128'(oSDRAM_Wr_Data3), 128'(16'h3333));
                check("sb_data4", 128'(oSDRAM_Wr_Data4), 128'(16'h4444));
                check("sb_grant", 128'(oGrant), 128'(3'b010));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int doneSeen;

    initial begin
        rst = 1'b1; iReq = '0; iSDRAM_Wr_Done = 1'b0; reqCnt = 0; prevGrant = '0;
        for (int k = 0; k < NREQ; k++) begin laneAddr[k] = '0; laneData[k] = '0; end
        doReset();

        // reset state
        check("rst_req",   128'(oSDRAM_Wr_Req), 128'(0));
        check("rst_grant", 128'(oGrant), 128'(0));
        check("rst_err",   128'({oErr, oErr_Src, oBusy, oDone}), 128'(0));

        // single burst on requester 1, done 5 cycles after the request
        fixedLane = 1; lat = 5; npend[1] = 1;
        step();
        watchBurst(9);
        check("sb_latency", 128'(firstReq), 128'(1));
        check("sb_reqlen",  128'(reqHigh), 128'(5));
        check("sb_donecnt", 128'(doneCnt), 128'(1));
        check("sb_doneat",  128'(doneAt), 128'(6));
        check("sb_doneval", 128'(doneVal), 128'(3'b010));

        // all three request at once
        doReset(); lat = 2;
        for (int k = 0; k < NREQ; k++) npend[k] = 1;
        drain(100, "rr_drain");
        check("rr_order", 128'(logCode()), 128'(27));     // 0,1,2

        // requester 0 re-requests while 2 waits
        doReset(); lat = 2; npend[0] = 2; npend[2] = 2;
        drain(100, "fair_drain");
        check("fair_order", 128'(logCode()), 128'(119));  // 0,2,0,2

        // controller never answers: watchdog
        doReset(); lat = 0; npend[2] = 1;
        step();
        watchBurst(22);
        check("to_reqlen",  128'(reqHigh), 128'(TO));
        check("to_donecnt", 128'(doneCnt), 128'(1));
        check("to_err",     128'(oErr), 128'(1));
        check("to_errsrc",  128'(oErr_Src), 128'(2));
        lat = 3; npend[0] = 1;
        drain(40, "to_next_drain");
        check("to_err_sticky", 128'(oErr), 128'(1));
        check("to_errsrc2",    128'(oErr_Src), 128'(2));
        check("to_order",      128'(logCode()), 128'(13)); // 2,0

        // done on the same cycle the watchdog would fire
        doReset(); lat = TO; npend[1] = 1;
        step();
        watchBurst(22);
        check("co_reqlen",  128'(reqHigh), 128'(TO));
        check("co_donecnt", 128'(doneCnt), 128'(1));
        check("co_err",     128'(oErr), 128'(0));

        // reset in the middle of a burst
        doReset(); lat = 0; npend[0] = 1;
        step(); step(); step(); step();
        check("mr_busy_before", 128'(oSDRAM_Wr_Req), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("mr_async", 128'({oSDRAM_Wr_Req, oGrant, oDone, oBusy}), 128'(0));
        doneSeen = 0;
        step(); if (oDone != 0) doneSeen++;
        rst = 1'b0;
        step();
        check("mr_regrant", 128'(oGrant), 128'(3'b001));
        check("mr_req",     128'(oSDRAM_Wr_Req), 128'(1));
        check("mr_nodone",  128'(doneSeen), 128'(0));
        lat = 2;
        drain(40, "mr_drain");
        check("mr_order", 128'(logCode()), 128'(5));       // 0 (aborted), 0

        // randomized traffic against the model
        for (int it = 0; it < 8; it++) begin
            doReset();
            randMode = 1;
            for (int k = 0; k < NREQ; k++) npend[k] = $urandom_range(0, 4);
            drain(3000, "rand_drain");
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
